// File: rtl/alu_sequencer.sv
// Request/response sequencer driving an external combinational ALU, one op in flight.
// Optional accumulator forwarding is enabled by defining ALU_SEQ_ACC_FORWARD_EN.
module alu_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 1
) (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic       Req_Valid,
  output logic       Req_Ready,
  input  logic [7:0] Req_Op,
  input  logic [7:0] Req_A,
  input  logic [7:0] Req_B,
  input  logic       Req_Use_Acc,
  output logic [7:0] Alu_A,
  output logic [7:0] Alu_B,
  output logic [7:0] Alu_Selector,
  input  logic [7:0] Alu_X,
  input  logic [7:0] Alu_Flags,
  output logic       Rsp_Valid,
  input  logic       Rsp_Ready,
  output logic [7:0] Rsp_X,
  output logic [7:0] Rsp_Flags,
  output logic       Rsp_Err,
  output logic [7:0] Flags_Reg,
  output logic       Busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, RESP} state_t;

  state_t     state_q;
  logic [3:0] cnt_q;
  logic [7:0] a_q, b_q, sel_q;
  logic [7:0] rsp_x_q, rsp_flags_q, flags_q;
  logic       rsp_err_q;
  logic [7:0] a_d;
  logic [7:0] flags_d;
  logic       capture;

  function automatic logic op_legal(input logic [7:0] op);
    return (op >= 8'h01) && (op <= 8'h0A);
  endfunction

  // Bits 4, 5 and 7 carry no architectural meaning and are always reported as zero.
  function automatic logic [7:0] mask_flags(input logic [7:0] f);
    return f & 8'b0100_1111;
  endfunction

  assign capture = (state_q == ISSUE) && (cnt_q == 4'd0);
  assign flags_d = mask_flags(Alu_Flags);

`ifdef ALU_SEQ_ACC_FORWARD_EN
  logic [7:0] acc_q;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      acc_q <= 8'h00;
    end else if (capture) begin
      acc_q <= Alu_X;
    end
  end

  assign a_d = Req_Use_Acc ? acc_q : Req_A;
`else
  logic unused_use_acc;
  assign unused_use_acc = Req_Use_Acc;
  assign a_d            = Req_A;
`endif

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= 4'd0;
      a_q         <= 8'h00;
      b_q         <= 8'h00;
      sel_q       <= 8'h00;
      rsp_x_q     <= 8'h00;
      rsp_flags_q <= 8'h00;
      rsp_err_q   <= 1'b0;
      flags_q     <= 8'h00;
    end else begin
      case (state_q)
        IDLE: begin
          if (Req_Valid) begin
            a_q <= a_d;
            b_q <= Req_B;
            if (op_legal(Req_Op)) begin
              sel_q   <= Req_Op;
              cnt_q   <= 4'(SETTLE_CYCLES);
              state_q <= ISSUE;
            end else begin
              rsp_x_q     <= 8'h00;
              rsp_flags_q <= 8'h00;
              rsp_err_q   <= 1'b1;
              state_q     <= RESP;
            end
          end
        end
        ISSUE: begin
          if (capture) begin
            rsp_x_q     <= Alu_X;
            rsp_flags_q <= flags_d;
            rsp_err_q   <= 1'b0;
            flags_q     <= flags_d;
            sel_q       <= 8'h00;
            state_q     <= RESP;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        RESP: begin
          if (Rsp_Ready) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign Req_Ready    = (state_q == IDLE);
  assign Rsp_Valid    = (state_q == RESP);
  assign Busy         = (state_q != IDLE);
  assign Alu_A        = a_q;
  assign Alu_B        = b_q;
  assign Alu_Selector = sel_q;
  assign Rsp_X        = rsp_x_q;
  assign Rsp_Flags    = rsp_flags_q;
  assign Rsp_Err      = rsp_err_q;
  assign Flags_Reg    = flags_q;

endmodule
